// File: rtl/vslc_pkg.sv
// Shared types and constants for the VSLC instruction fetch path.
// Fetch FSM states, header byte offsets and the default address width.
package vslc_pkg;

    localparam int ADDR_W_DEF   = 10;

    localparam int HDR_START_HI = 0;
    localparam int HDR_START_LO = 1;
    localparam int HDR_END_HI   = 2;
    localparam int HDR_END_LO   = 3;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_IDLE,
        ST_SEEK,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/vslc_byte_fifo.sv
// Small synchronous FIFO with flop storage; head is read straight from flops.
// Push when full is accepted only if a pop happens in the same cycle.
module vslc_byte_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [W-1:0]        wdata,
    input  logic                pop,
    output logic [W-1:0]        rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

    logic [W-1:0]          mem_q [DEPTH];
    logic [W-1:0]          mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vslc_instr_fetch.sv
// Header parse, program-byte buffering and EEPROM flow control for the executor.
// Define VSLC_FETCH_SCAN_COUNT_EN to enable the completed-scan counter.
module vslc_instr_fetch
    import vslc_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int HOLD_MARGIN = 1,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rd_byte,
    input  logic [15:0]       rd_addr,
    input  logic              rd_ready,
    output logic              eeprom_hold_n,
    output logic              restart_read,
    output logic [ADDR_W-1:0] start_addr,
    output logic [7:0]        instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              scan_start,
    output logic              hdr_err,
    output logic              overflow,
    output logic [15:0]       scan_count
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(2 ** DEPTH_LOG2);
    localparam logic [CW-1:0] MARGIN_C = CW'(HOLD_MARGIN);

    fetch_state_e      state_q, state_d;
    logic              rd_ready_q;
    logic [ADDR_W-1:0] start_q, start_d, end_q, end_d;
    logic              chk_q, chk_d;
    logic              scan_q, scan_d;
    logic              restart_q, restart_d;
    logic              hdr_err_q, hdr_err_d;
    logic              ovf_q, ovf_d;
    logic              hold_q, hold_d;

    logic              byte_stb, in_rng, run_st;
    logic              push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, free;
    logic [ADDR_W-1:0] addr;

    assign byte_stb    = rd_ready && !rd_ready_q;
    assign in_rng      = (rd_addr[15:ADDR_W] == '0);
    assign addr        = rd_addr[ADDR_W-1:0];
    assign run_st      = (state_q == ST_SEEK) || (state_q == ST_RUN)
                      || (state_q == ST_DRAIN);
    assign instr_valid = run_st && !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign free        = DEPTH_C - fifo_count;

    vslc_byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .W         (8)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(rd_byte),
        .pop  (pop),
        .rdata(instr),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        chk_d     = 1'b0;
        scan_d    = 1'b0;
        restart_d = 1'b0;
        hdr_err_d = hdr_err_q;
        push      = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (chk_q) begin
                    if (end_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (end_q < start_q) begin
                        state_d   = ST_IDLE;
                        hdr_err_d = 1'b1;
                    end else begin
                        state_d = ST_SEEK;
                    end
                end else if (byte_stb) begin
                    if (rd_addr == 16'(HDR_START_HI)) begin
                        start_d = {rd_byte[ADDR_W-9:0], start_q[7:0]};
                    end else if (rd_addr == 16'(HDR_START_LO)) begin
                        start_d = {start_q[ADDR_W-1:8], rd_byte};
                    end else if (rd_addr == 16'(HDR_END_HI)) begin
                        end_d = {rd_byte[ADDR_W-9:0], end_q[7:0]};
                    end else if (rd_addr == 16'(HDR_END_LO)) begin
                        end_d = {end_q[ADDR_W-1:8], rd_byte};
                        chk_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SEEK: begin
                if (byte_stb && in_rng && addr == start_q) begin
                    push    = 1'b1;
                    scan_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (byte_stb) begin
                    // Out-of-window bytes end the scan without being buffered.
                    if (!in_rng || addr > end_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        push = 1'b1;
                        if (addr == end_q) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    restart_d = 1'b1;
                    state_d   = ST_SEEK;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_comb begin
        ovf_d  = ovf_q || (push && fifo_full && !pop);
        hold_d = !(free <= MARGIN_C);
        if (state_q == ST_DRAIN || state_q == ST_IDLE) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            rd_ready_q <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            chk_q      <= 1'b0;
            scan_q     <= 1'b0;
            restart_q  <= 1'b0;
            hdr_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rd_ready_q <= rd_ready;
            start_q    <= start_d;
            end_q      <= end_d;
            chk_q      <= chk_d;
            scan_q     <= scan_d;
            restart_q  <= restart_d;
            hdr_err_q  <= hdr_err_d;
            ovf_q      <= ovf_d;
            hold_q     <= hold_d;
        end
    end

    assign eeprom_hold_n = hold_q;
    assign restart_read  = restart_q;
    assign start_addr    = start_q;
    assign scan_start    = scan_q;
    assign hdr_err       = hdr_err_q;
    assign overflow      = ovf_q;

`ifdef VSLC_FETCH_SCAN_COUNT_EN
    logic [15:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = scnt_q;
        if (restart_d) begin
            scnt_d = scnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign scan_count = scnt_q;
`else
    assign scan_count = '0;
`endif

endmodule

// File: tb/tb_vslc_instr_fetch.sv
// Directed and randomized bench for vslc_instr_fetch with a byte-stream model.
// Expected instruction streams are derived from header window rules.
module tb_vslc_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_byte = '0;
    logic [15:0] rd_addr = '0;
    logic        rd_ready = 1'b0;
    logic        instr_ready = 1'b0;
    logic        eeprom_hold_n, restart_read, instr_valid;
    logic        scan_start, hdr_err, overflow;
    logic [9:0]  start_addr;
    logic [7:0]  instr;
    logic [15:0] scan_count;

    int          n_chk = 0;
    int          n_fail = 0;
    int          got_n = 0;
    int          ss_cnt = 0;
    int          rs_cnt = 0;
    int          vld_cyc = 0;
    logic [7:0]  got_mem [0:1023];
    logic [7:0]  exp_q [$];
    logic [7:0]  pmem [0:63];

    vslc_instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_byte      (rd_byte),
        .rd_addr      (rd_addr),
        .rd_ready     (rd_ready),
        .eeprom_hold_n(eeprom_hold_n),
        .restart_read (restart_read),
        .start_addr   (start_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .scan_start   (scan_start),
        .hdr_err      (hdr_err),
        .overflow     (overflow),
        .scan_count   (scan_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready && got_n < 1024) begin
                got_mem[got_n] <= instr;
                got_n <= got_n + 1;
            end
            if (instr_valid) vld_cyc <= vld_cyc + 1;
            if (scan_start) ss_cnt <= ss_cnt + 1;
            if (restart_read) rs_cnt <= rs_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_scans(input int n);
`ifdef VSLC_FETCH_SCAN_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic strobe(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        rd_addr  = a;
        rd_byte  = d;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic send_hdr(input logic [9:0] s, input logic [9:0] e);
        strobe(16'd0, {6'd0, s[9:8]});
        strobe(16'd1, s[7:0]);
        strobe(16'd2, {6'd0, e[9:8]});
        strobe(16'd3, e[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        rd_ready    = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_restart(input int target);
        int n = 0;
        while (rs_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("restart_seen", 32'(rs_cnt >= target), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        check({tag, "_len"}, 32'(got_n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < 1024) check(tag, got_mem[base+i], exp_q[i]);
        end
    endtask

    initial begin
        int b0, bss, brs, bvl, s_a, e_a;

        repeat (2) @(negedge clk);
        check("rst_hold_n", eeprom_hold_n, 1);
        check("rst_valid", instr_valid, 0);
        check("rst_restart", restart_read, 0);
        check("rst_start", start_addr, 0);
        check("rst_scan_start", scan_start, 0);
        check("rst_hdr_err", hdr_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_scan_count", scan_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan: window 4..7, executor always ready.
        instr_ready = 1'b1;
        send_hdr(10'd4, 10'd7);
        b0 = got_n; bss = ss_cnt; brs = rs_cnt;
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA1 + i));
        strobe(16'd4, 8'hA1);
        check("scan_start_first", scan_start, 1);
        for (int i = 1; i < 4; i++) strobe(16'(4 + i), 8'(8'hA1 + i));
        wait_restart(brs + 1);
        repeat (10) @(negedge clk);
        check_seq("scan1", b0);
        check("scan1_ss", 32'(ss_cnt - bss), 1);
        check("scan1_rs", 32'(rs_cnt - brs), 1);
        check("scan1_start", start_addr, 4);
        check("scan1_count", scan_count, 32'(exp_scans(1)));

        // end_addr == 0: no program.
        do_reset();
        instr_ready = 1'b1;
        bvl = vld_cyc; brs = rs_cnt; bss = ss_cnt;
        send_hdr(10'd4, 10'd0);
        for (int a = 4; a < 9; a++) strobe(16'(a), 8'(a));
        repeat (4) @(negedge clk);
        check("idle_valid", 32'(vld_cyc - bvl), 0);
        check("idle_rs", 32'(rs_cnt - brs), 0);
        check("idle_ss", 32'(ss_cnt - bss), 0);
        check("idle_hold", eeprom_hold_n, 1);
        check("idle_hdr_err", hdr_err, 0);

        // end < start: header error.
        do_reset();
        instr_ready = 1'b1;
        bvl = vld_cyc; brs = rs_cnt;
        send_hdr(10'd8, 10'd5);
        @(negedge clk);
        check("herr_flag", hdr_err, 1);
        strobe(16'd8, 8'h55);
        strobe(16'd5, 8'h66);
        repeat (3) @(negedge clk);
        check("herr_valid", 32'(vld_cyc - bvl), 0);
        check("herr_rs", 32'(rs_cnt - brs), 0);
        check("herr_start", start_addr, 8);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        send_hdr(10'h010, 10'h03F);
        exp_q = {};
        for (int i = 0; i < 5; i++) pmem[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) exp_q.push_back(pmem[i]);
        b0 = got_n;
        for (int i = 0; i < 4; i++) strobe(16'(16 + i), pmem[i]);
        @(negedge clk);
        check("full_hold", eeprom_hold_n, 0);
        rd_addr = 16'd20; rd_byte = pmem[4];
        rd_ready = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        check("pp_overflow", overflow, 0);
        check("pp_hold", eeprom_hold_n, 0);
        check("pp_valid", instr_valid, 1);
        instr_ready = 1'b1;
        repeat (8) @(negedge clk);
        instr_ready = 1'b0;
        check_seq("pp_order", b0);

        // Hold latency and overflow.
        do_reset();
        send_hdr(10'h010, 10'h03F);
        exp_q = {};
        for (int i = 0; i < 5; i++) pmem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) exp_q.push_back(pmem[i]);
        b0 = got_n;
        strobe(16'd16, pmem[0]);
        strobe(16'd17, pmem[1]);
        check("hold_two", eeprom_hold_n, 1);
        strobe(16'd18, pmem[2]);
        check("hold_lat", eeprom_hold_n, 1);
        @(negedge clk);
        check("hold_low", eeprom_hold_n, 0);
        strobe(16'd19, pmem[3]);
        check("ovf_before", overflow, 0);
        strobe(16'd20, pmem[4]);
        check("ovf_set", overflow, 1);
        instr_ready = 1'b1;
        repeat (8) @(negedge clk);
        instr_ready = 1'b0;
        check_seq("ovf_keep", b0);
        check("ovf_empty", instr_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset in RUN with two bytes buffered, then re-parse.
        do_reset();
        send_hdr(10'd4, 10'd20);
        strobe(16'd4, 8'h11);
        strobe(16'd5, 8'h22);
        check("mid_valid_pre", instr_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_valid_rst", instr_valid, 0);
        check("mid_hold_rst", eeprom_hold_n, 1);
        check("mid_start_rst", start_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        exp_q = {8'h33, 8'h44};
        b0 = got_n; brs = rs_cnt;
        send_hdr(10'd6, 10'd7);
        strobe(16'd4, 8'h99);
        strobe(16'd5, 8'h98);
        strobe(16'd6, 8'h33);
        strobe(16'd7, 8'h44);
        strobe(16'd8, 8'h97);
        wait_restart(brs + 1);
        repeat (4) @(negedge clk);
        check_seq("mid_reparse", b0);
        check("mid_start", start_addr, 6);

        // Randomized windows, two scans each.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            instr_ready = 1'b1;
            s_a = int'($urandom_range(30, 4));
            e_a = s_a + int'($urandom_range(5, 0));
            for (int a = 0; a < 64; a++) pmem[a] = 8'($urandom);
            exp_q = {};
            for (int k = 0; k < 2; k++)
                for (int a = s_a; a <= e_a; a++) exp_q.push_back(pmem[a]);
            b0 = got_n; brs = rs_cnt; bss = ss_cnt;
            send_hdr(10'(s_a), 10'(e_a));
            for (int a = 4; a <= e_a + 2; a++) strobe(16'(a), pmem[a]);
            wait_restart(brs + 1);
            for (int a = s_a; a <= e_a + 1; a++) strobe(16'(a), pmem[a]);
            wait_restart(brs + 2);
            repeat (4) @(negedge clk);
            check_seq("rand_scan", b0);
            check("rand_ss", 32'(ss_cnt - bss), 2);
            check("rand_rs", 32'(rs_cnt - brs), 2);
            check("rand_start", start_addr, 32'(s_a));
            check("rand_count", scan_count, 32'(exp_scans(2)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
